// File: rtl/ldpc_dvb_dec_types.sv
// Shared types for the DVB-S2 LDPC decoder sort scheduler slice.
// Strobe bundle, minimum-column type and scheduler state encoding.
package ldpc_dvb_dec_types;

    localparam int cCOL_W = 5;

    typedef logic [cCOL_W-1:0] vn_min_col_t;

    typedef struct packed {
        logic sop;
        logic eop;
    } strb_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ROW,
        ST_DRAIN,
        ST_CHECK,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/ldpc_dvb_dec_strb_delay.sv
// Delays the sort-engine strobes so they meet the vnode memory read data.
// Clock-enable gated; a frozen clock never duplicates or drops a strobe.
module ldpc_dvb_dec_strb_delay
    import ldpc_dvb_dec_types::*;
#(
    parameter int pLAT = 2
) (
    input  logic  iclk,
    input  logic  ireset,
    input  logic  iclkena,
    input  logic  ival,
    input  strb_t istrb,
    input  logic  imask,
    output logic  oval,
    output strb_t ostrb,
    output logic  omask
);

    typedef struct packed {
        logic  val;
        strb_t strb;
        logic  mask;
    } dly_t;

    dly_t sr [pLAT];

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            for (int i = 0; i < pLAT; i++) begin
                sr[i] <= '0;
            end
        end else if (iclkena) begin
            sr[0] <= {ival, istrb, imask};
            for (int i = 1; i < pLAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign oval  = sr[pLAT-1].val;
    assign ostrb = sr[pLAT-1].strb;
    assign omask = sr[pLAT-1].mask;

endmodule

// File: rtl/ldpc_dvb_dec_sort_sched.sv
// Row/iteration scheduler feeding the serial min-sum sort engine.
// Walks rows column by column and decides continue/early-stop/limit per iteration.
module ldpc_dvb_dec_sort_sched
    import ldpc_dvb_dec_types::*;
#(
    parameter int pROW_W   = 8,
    parameter int pCOL_W   = 5,
    parameter int pITER_W  = 6,
    parameter int pMEM_LAT = 2
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               istart,
    input  logic [pROW_W-1:0]  irow_num_m1,
    input  logic [pITER_W-1:0] iiter_max_m1,
    input  logic [pCOL_W-1:0]  irow_deg_m1,
    input  logic               ipunct,
    output logic               osort_start,
    output logic [pROW_W-1:0]  orow_addr,
    output logic [pCOL_W-1:0]  ocol_addr,
    output logic               ordena,
    output logic               oval,
    output logic               osop,
    output logic               oeop,
    output logic               ovmask,
    input  logic               isort_val,
    input  logic               idecfail,
    output logic               obusy,
    output logic               odone,
    output logic               oearly,
    output logic [pITER_W-1:0] oiter_m1
);

    sched_state_t       state;
    logic [pROW_W-1:0]  row;
    logic [pROW_W-1:0]  row_num_m1;
    logic [pROW_W:0]    rows;
    logic [pROW_W:0]    res_cnt;
    logic [pCOL_W-1:0]  col;
    logic [pCOL_W-1:0]  deg;
    logic [pCOL_W-1:0]  deg_cur;
    logic [pITER_W-1:0] iter;
    logic [pITER_W-1:0] iter_max_m1;
    logic               rd;
    logic               sop;
    logic               eop;
    logic               res_sat;
    logic               res_en;
    strb_t              strb_in;
    strb_t              strb_out;

    // The degree table is only valid for the new row at column 0
    assign deg_cur = (col == '0) ? irow_deg_m1 : deg;
    assign sop     = (col == '0);
    assign eop     = (col == deg_cur);
    assign rd      = (state == ST_ROW);
    assign res_sat = &res_cnt;
    assign res_en  = isort_val && !res_sat &&
                     (state == ST_ROW || state == ST_DRAIN);

    assign ordena    = rd;
    assign orow_addr = row;
    assign ocol_addr = col;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state       <= ST_IDLE;
            row         <= '0;
            row_num_m1  <= '0;
            rows        <= '0;
            res_cnt     <= '0;
            col         <= '0;
            deg         <= '0;
            iter        <= '0;
            iter_max_m1 <= '0;
            osort_start <= 1'b0;
            obusy       <= 1'b0;
            odone       <= 1'b0;
            oearly      <= 1'b0;
            oiter_m1    <= '0;
        end else if (iclkena) begin
            osort_start <= 1'b0;
            odone       <= 1'b0;
            if (res_en) begin
                res_cnt <= res_cnt + (pROW_W+1)'(1);
            end
            unique case (state)
                ST_IDLE: begin
                    if (istart) begin
                        row_num_m1  <= irow_num_m1;
                        rows        <= {1'b0, irow_num_m1} + (pROW_W+1)'(1);
                        iter_max_m1 <= iiter_max_m1;
                        iter        <= '0;
                        obusy       <= 1'b1;
                        osort_start <= 1'b1;
                        state       <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    row     <= '0;
                    col     <= '0;
                    res_cnt <= '0;
                    state   <= ST_ROW;
                end
                ST_ROW: begin
                    if (col == '0) begin
                        deg <= irow_deg_m1;
                    end
                    if (eop) begin
                        col <= '0;
                        if (row == row_num_m1) begin
                            state <= ST_DRAIN;
                        end else begin
                            row <= row + pROW_W'(1);
                        end
                    end else begin
                        col <= col + pCOL_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (res_cnt == rows) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!idecfail || iter == iter_max_m1) begin
                        state    <= ST_DONE;
                        odone    <= 1'b1;
                        obusy    <= 1'b0;
                        oearly   <= !idecfail;
                        oiter_m1 <= iter;
                    end else begin
                        iter        <= iter + pITER_W'(1);
                        osort_start <= 1'b1;
                        state       <= ST_INIT;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign strb_in = '{sop: sop, eop: eop};

    ldpc_dvb_dec_strb_delay #(
        .pLAT (pMEM_LAT)
    ) u_dly (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ival    (rd),
        .istrb   (strb_in),
        .imask   (ipunct & rd),
        .oval    (oval),
        .ostrb   (strb_out),
        .omask   (ovmask)
    );

    assign osop = strb_out.sop;
    assign oeop = strb_out.eop;

endmodule

// File: tb/tb_ldpc_dvb_dec_sort_sched.sv
// Self-checking bench for the sort scheduler: vector table plus scoreboard
// of expected addresses and delayed strobes, with reset and busy-start sequences.
module tb_ldpc_dvb_dec_sort_sched;

    logic       iclk = 1'b0;
    logic       ireset = 1'b1;
    logic       iclkena = 1'b1;
    logic       istart = 1'b0;
    logic [7:0] irow_num_m1 = '0;
    logic [5:0] iiter_max_m1 = '0;
    logic [4:0] irow_deg_m1;
    logic       ipunct;
    logic       isort_val;
    logic       idecfail = 1'b0;
    logic       osort_start;
    logic [7:0] orow_addr;
    logic [4:0] ocol_addr;
    logic       ordena;
    logic       oval;
    logic       osop;
    logic       oeop;
    logic       ovmask;
    logic       obusy;
    logic       odone;
    logic       oearly;
    logic [5:0] oiter_m1;

    ldpc_dvb_dec_sort_sched dut (
        .iclk         (iclk),
        .ireset       (ireset),
        .iclkena      (iclkena),
        .istart       (istart),
        .irow_num_m1  (irow_num_m1),
        .iiter_max_m1 (iiter_max_m1),
        .irow_deg_m1  (irow_deg_m1),
        .ipunct       (ipunct),
        .osort_start  (osort_start),
        .orow_addr    (orow_addr),
        .ocol_addr    (ocol_addr),
        .ordena       (ordena),
        .oval         (oval),
        .osop         (osop),
        .oeop         (oeop),
        .ovmask       (ovmask),
        .isort_val    (isort_val),
        .idecfail     (idecfail),
        .obusy        (obusy),
        .odone        (odone),
        .oearly       (oearly),
        .oiter_m1     (oiter_m1)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int rows_m1;
        int deg_m1;
        int iter_m1;
        bit decfail;
        int punct;
        bit rnd;
        bit exp_early;
        int exp_iter;
        int exp_rd;
        int exp_starts;
    } vec_t;

    typedef struct packed {
        logic [7:0] row;
        logic [4:0] col;
    } addr_t;

    vec_t vecs[6];
    int   n_vec = 0;
    int   n_err = 0;

    int   cur_deg = 0;
    int   cur_punct = 31;
    bit   rand_en = 1'b0;

    addr_t      addr_q[$];
    logic [2:0] strb_q[$];
    int         rd_cnt, start_cnt, val_cnt, done_cnt, got_iter;
    bit         got_early;
    logic [1:0] rd_hist = '0;
    logic [2:0] eng = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Memory/table model and a fixed-latency sort engine
    assign irow_deg_m1 = 5'(cur_deg);
    assign ipunct      = (int'(ocol_addr) == cur_punct);
    assign isort_val   = eng[2];

    always @(negedge iclk) begin
        if (ireset) eng = '0;
        else if (iclkena) eng = {eng[1:0], oval & oeop};
    end

    always @(posedge iclk) begin
        #1;
        iclkena = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard: one evaluation per enabled tick
    always @(negedge iclk) begin
        addr_t      a;
        logic [2:0] s;
        if (ireset) begin
            rd_hist = '0;
        end else if (iclkena) begin
            check("align", oval, rd_hist[1]);
            rd_hist = {rd_hist[0], ordena};
            if (osort_start) start_cnt++;
            if (ordena) begin
                rd_cnt++;
                if (addr_q.size() == 0) begin
                    fail("addr_extra");
                end else begin
                    a = addr_q.pop_front();
                    check("row", orow_addr, a.row);
                    check("col", ocol_addr, a.col);
                    strb_q.push_back({int'(a.col) == 0, int'(a.col) == cur_deg,
                                      int'(a.col) == cur_punct});
                end
            end
            if (oval) begin
                val_cnt++;
                if (strb_q.size() == 0) begin
                    fail("strobe_extra");
                end else begin
                    s = strb_q.pop_front();
                    check("strobe", {osop, oeop, ovmask}, s);
                end
            end
            if (odone) begin
                done_cnt++;
                got_early = oearly;
                got_iter  = oiter_m1;
                check("busy_at_done", obusy, 0);
            end
        end
    end

    task automatic prep(input vec_t v, input int iters);
        rand_en      = v.rnd;
        cur_deg      = v.deg_m1;
        cur_punct    = v.punct;
        irow_num_m1  = 8'(v.rows_m1);
        iiter_max_m1 = 6'(v.iter_m1);
        idecfail     = v.decfail;
        addr_q.delete();
        strb_q.delete();
        rd_cnt = 0; start_cnt = 0; val_cnt = 0; done_cnt = 0;
        got_iter = -1; got_early = 1'b0;
        for (int it = 0; it < iters; it++)
            for (int r = 0; r <= v.rows_m1; r++)
                for (int c = 0; c <= v.deg_m1; c++)
                    addr_q.push_back('{row: 8'(r), col: 5'(c)});
    endtask

    task automatic start_pulse();
        @(negedge iclk);
        istart = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(posedge iclk);
            if (iclkena) break;
        end
        #2 istart = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int guard = 0;
        while (done_cnt == 0 && guard < 5000) begin
            @(negedge iclk);
            #1;
            guard++;
        end
        if (done_cnt == 0) fail({tag, ".timeout"});
    endtask

    task automatic final_checks(input vec_t v, input string tag);
        check({tag, ".rd"}, rd_cnt, v.exp_rd);
        check({tag, ".val"}, val_cnt, v.exp_rd);
        check({tag, ".starts"}, start_cnt, v.exp_starts);
        check({tag, ".done"}, done_cnt, 1);
        check({tag, ".early"}, got_early, v.exp_early);
        check({tag, ".iter"}, got_iter, v.exp_iter);
        check({tag, ".addr_left"}, addr_q.size(), 0);
        check({tag, ".busy_idle"}, obusy, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        prep(v, v.exp_iter + 1);
        start_pulse();
        wait_done(tag);
        repeat (4) @(negedge iclk);
        #1;
        rand_en = 1'b0;
        final_checks(v, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int guard;
        //          rows deg iter df punct rnd  early iter rd starts
        vecs[0] = '{2, 4, 3, 1'b0, 31, 1'b0, 1'b1, 0, 15, 1};
        vecs[1] = '{2, 4, 3, 1'b1, 31, 1'b0, 1'b0, 3, 60, 4};
        vecs[2] = '{4, 0, 2, 1'b0, 31, 1'b0, 1'b1, 0, 5, 1};
        vecs[3] = '{2, 4, 3, 1'b0, 31, 1'b1, 1'b1, 0, 15, 1};
        vecs[4] = '{2, 3, 1, 1'b1, 2, 1'b0, 1'b0, 1, 24, 2};
        vecs[5] = '{0, 0, 0, 1'b1, 0, 1'b1, 1'b0, 0, 1, 1};

        #12;
        check("reset_state", {osort_start, orow_addr, ocol_addr, ordena, oval, osop,
                              oeop, ovmask, obusy, odone, oearly, oiter_m1}, 0);
        @(negedge iclk);
        ireset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while draining the first iteration
        prep(vecs[1], 1);
        start_pulse();
        guard = 0;
        while (rd_cnt < 15 && guard < 1000) begin
            @(negedge iclk);
            #1;
            guard++;
        end
        if (rd_cnt < 15) fail("rst.timeout");
        @(negedge iclk);
        @(negedge iclk);
        #1;
        ireset = 1'b1;
        @(posedge iclk);
        #1;
        check("rst_outputs", {osort_start, orow_addr, ocol_addr, ordena, oval, osop,
                              oeop, ovmask, obusy, odone}, 0);
        addr_q.delete();
        strb_q.delete();
        repeat (3) @(negedge iclk);
        ireset = 1'b0;
        repeat (20) @(negedge iclk);
        #1;
        check("rst_no_done", done_cnt, 0);
        check("rst_idle", {obusy, ordena}, 0);
        run_vec(vecs[0], "post_rst");

        // istart while busy and with odone must be ignored
        prep(vecs[0], 1);
        start_pulse();
        repeat (6) @(negedge iclk);
        irow_num_m1 = 8'd7;
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
        wait_done("busy");
        istart = 1'b1;
        @(posedge iclk);
        #2 istart = 1'b0;
        repeat (12) @(negedge iclk);
        #1;
        final_checks(vecs[0], "busy");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
